// File: rtl/fixed_int26_6_accumulate.sv
// fixed_int26_6_accumulate
// Sums a frame of N signed 26.6 terms into a wide accumulator and emits one
// saturated 32-bit 26.6 result per frame. N arrives on a separate length
// stream. Every stream uses Ready/Data/Stop: a word moves when Ready=1, Stop=0.
// Stop outputs come straight from flops, so no Ready input reaches a Stop output.

module fixed_int26_6_accumulate #(
    parameter int COUNT_WIDTH = 16,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                   clk,
    input  logic                   srst,

    input  logic                   goValid,
    output logic                   goStop,
    output logic                   doneValid,
    input  logic                   doneStop,

    input  logic                   lengthReady,
    input  logic [COUNT_WIDTH-1:0] lengthData,
    output logic                   lengthStop,

    input  logic                   termsReady,
    input  logic [31:0]            termsData,
    output logic                   termsStop,

    output logic                   resultReady,
    output logic [31:0]            resultData,
    input  logic                   resultStop
);

    typedef enum logic [1:0] {
        S_WAIT_LEN = 2'd0,
        S_ACCUM    = 2'd1,
        S_OUTPUT   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   term_ext;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;
    logic [31:0]                   result_data_q, result_data_d;
    logic                          result_ready_q, result_ready_d;
    logic                          length_stop_q, length_stop_d;
    logic                          terms_stop_q, terms_stop_d;

    logic                          len_xfer;
    logic                          term_xfer;
    logic                          res_xfer;

    // Clamp the wide sum into signed 32-bit range. The value fits exactly when
    // every bit from 31 upward equals the sign bit; otherwise pick the rail
    // on the side of the sign. The binary point is not moved.
    function automatic logic [31:0] sat32(input logic signed [ACC_WIDTH-1:0] x);
        logic [ACC_WIDTH-32:0] upper;
        upper = x[ACC_WIDTH-1:31];
        if ((&upper) || (~|upper)) begin
            sat32 = x[31:0];
        end else if (x[ACC_WIDTH-1]) begin
            sat32 = 32'h8000_0000;
        end else begin
            sat32 = 32'h7FFF_FFFF;
        end
    endfunction

    // Go/done is a plain pass-through, untouched by reset or frame state.
    assign doneValid = goValid;
    assign goStop    = doneStop;

    assign lengthStop  = length_stop_q;
    assign termsStop   = terms_stop_q;
    assign resultReady = result_ready_q;
    assign resultData  = result_data_q;

    // Handshakes qualified by the registered Stop/Ready flops only.
    assign len_xfer  = lengthReady & ~length_stop_q;
    assign term_xfer = termsReady  & ~terms_stop_q;
    assign res_xfer  = result_ready_q & ~resultStop;

    assign term_ext = {{(ACC_WIDTH-32){termsData[31]}}, termsData};
    assign acc_next = acc_q + term_ext;

    // Frame sequencing: take a length, consume N terms, present the result.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        result_data_d  = result_data_q;
        result_ready_d = result_ready_q;

        unique case (state_q)
            S_WAIT_LEN: begin
                if (len_xfer) begin
                    acc_d   = '0;
                    count_d = lengthData;
                    if (lengthData == '0) begin
                        result_data_d  = 32'h0;
                        result_ready_d = 1'b1;
                        state_d        = S_OUTPUT;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (term_xfer) begin
                    acc_d   = acc_next;
                    count_d = count_q - 1'b1;
                    if (count_q == COUNT_WIDTH'(1)) begin
                        result_data_d  = sat32(acc_next);
                        result_ready_d = 1'b1;
                        state_d        = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                if (res_xfer) begin
                    result_ready_d = 1'b0;
                    state_d        = S_WAIT_LEN;
                end
            end
            default: begin
                result_ready_d = 1'b0;
                state_d        = S_WAIT_LEN;
            end
        endcase

        // Stops are decoded from the next state so they are flop outputs.
        length_stop_d = (state_d != S_WAIT_LEN);
        terms_stop_d  = (state_d != S_ACCUM);
    end

    // State, accumulator and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q        <= S_WAIT_LEN;
            acc_q          <= '0;
            count_q        <= '0;
            result_data_q  <= 32'h0;
            result_ready_q <= 1'b0;
            length_stop_q  <= 1'b0;
            terms_stop_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            result_data_q  <= result_data_d;
            result_ready_q <= result_ready_d;
            length_stop_q  <= length_stop_d;
            terms_stop_q   <= terms_stop_d;
        end
    end

endmodule
